// File: rtl/exc_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exc_ctrl_if : MEM-stage, CP0 and fetch-redirect signals of exc_ctrl   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface exc_ctrl_if;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_delayslot_i;
   logic        mem_adel_i;
   logic        mem_syscall_i;
   logic        mem_break_i;
   logic        mem_overflow_i;
   logic        mem_ades_i;
   logic        mem_eret_i;
   logic [5:0]  int_i;
   logic        timer_int_i;
   logic [31:0] cp0_epc_i;

   logic        address_read_error_flag_o;
   logic        syscall_flag_o;
   logic        break_flag_o;
   logic        overflow_flag_o;
   logic        address_write_error_flag_o;
   logic        eret_flag_o;
   logic        delayslot_flag_o;
   logic [31:0] current_pc_addr_o;
   logic [5:0]  int_o;
   logic        flush_o;
   logic        stall_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;

   // The pipeline/CP0 environment drives the MEM view and consumes the results.
   modport master (
      output mem_valid_i, mem_pc_i, mem_delayslot_i,
      output mem_adel_i, mem_syscall_i, mem_break_i,
      output mem_overflow_i, mem_ades_i, mem_eret_i,
      output int_i, timer_int_i, cp0_epc_i,
      input  address_read_error_flag_o, syscall_flag_o, break_flag_o,
      input  overflow_flag_o, address_write_error_flag_o, eret_flag_o,
      input  delayslot_flag_o, current_pc_addr_o, int_o,
      input  flush_o, stall_o, redirect_valid_o, redirect_pc_o
   );

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_delayslot_i,
      input  mem_adel_i, mem_syscall_i, mem_break_i,
      input  mem_overflow_i, mem_ades_i, mem_eret_i,
      input  int_i, timer_int_i, cp0_epc_i,
      output address_read_error_flag_o, syscall_flag_o, break_flag_o,
      output overflow_flag_o, address_write_error_flag_o, eret_flag_o,
      output delayslot_flag_o, current_pc_addr_o, int_o,
      output flush_o, stall_o, redirect_valid_o, redirect_pc_o
   );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | exc_ctrl : MEM/WB exception controller - event select, flush, redirect |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic      clk,
   input  logic      rst,
   exc_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  pulse_q, pulse_d;
   logic        ds_q, ds_d;
   logic [31:0] pc_q, pc_d;
   logic        is_eret_q, is_eret_d;
   logic [5:0]  sync1_q, sync2_q;
   logic [5:0]  sel;
   logic        event_hit;

   // One-hot select {adel, syscall, break, overflow, ades, eret}, highest first.
   always_comb begin
      sel = '0;
      if (bus.mem_valid_i) begin
         if (bus.mem_adel_i)          sel[5] = 1'b1;
         else if (bus.mem_syscall_i)  sel[4] = 1'b1;
         else if (bus.mem_break_i)    sel[3] = 1'b1;
         else if (bus.mem_overflow_i) sel[2] = 1'b1;
         else if (bus.mem_ades_i)     sel[1] = 1'b1;
         else if (bus.mem_eret_i)     sel[0] = 1'b1;
      end
   end

   assign event_hit = |sel;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_d   = '0;
      ds_d      = ds_q;
      pc_d      = pc_q;
      is_eret_d = is_eret_q;
      case (state_q)
         S_IDLE: begin
            if (event_hit) begin
               state_d   = S_FLUSH;
               pulse_d   = sel;
               ds_d      = bus.mem_delayslot_i;
               pc_d      = bus.mem_pc_i;
               is_eret_d = sel[0];
               cnt_d     = CNT_LOAD;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 4'd0) state_d = S_REDIRECT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_REDIRECT: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pulse_q   <= '0;
         ds_q      <= 1'b0;
         pc_q      <= '0;
         is_eret_q <= 1'b0;
         sync1_q   <= '0;
         sync2_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         ds_q      <= ds_d;
         pc_q      <= pc_d;
         is_eret_q <= is_eret_d;
         sync1_q   <= bus.int_i;
         sync2_q   <= sync1_q;
      end
   end

   assign bus.address_read_error_flag_o  = pulse_q[5];
   assign bus.syscall_flag_o             = pulse_q[4];
   assign bus.break_flag_o               = pulse_q[3];
   assign bus.overflow_flag_o            = pulse_q[2];
   assign bus.address_write_error_flag_o = pulse_q[1];
   assign bus.eret_flag_o                = pulse_q[0];
   assign bus.delayslot_flag_o           = ds_q;
   assign bus.current_pc_addr_o          = pc_q;

   assign bus.flush_o          = (state_q == S_FLUSH);
   assign bus.stall_o          = (state_q == S_FLUSH) || (state_q == S_REDIRECT);
   assign bus.redirect_valid_o = (state_q == S_REDIRECT);
   // EPC is read live in REDIRECT; CP0 only rewrites it on exceptions.
   assign bus.redirect_pc_o    = (state_q != S_REDIRECT) ? 32'd0 :
                                 (is_eret_q ? bus.cp0_epc_i : EXC_VECTOR);

   assign bus.int_o = {sync2_q[5] | bus.timer_int_i, sync2_q[4:0]};
endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_exc_ctrl : scoreboard bench for exc_ctrl                           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_exc_ctrl;
   localparam logic [31:0] EXC_VEC      = 32'hBFC00380;
   localparam int          FLUSH_CYCLES = 2;
   // flag order {adel, syscall, break, overflow, ades, eret}
   localparam logic [5:0] F_ADEL = 6'b100000;
   localparam logic [5:0] F_SYS  = 6'b010000;
   localparam logic [5:0] F_BRK  = 6'b001000;
   localparam logic [5:0] F_OVF  = 6'b000100;
   localparam logic [5:0] F_ADES = 6'b000010;
   localparam logic [5:0] F_ERET = 6'b000001;

   typedef struct {
      bit          is_redir;
      logic [5:0]  flags;
      logic [31:0] pc;
      logic        ds;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   flush_run = 0;
   int   stall_run = 0;
   logic [5:0] flags_mon;

   exc_ctrl_if bus();

   exc_ctrl #(.EXC_VECTOR(EXC_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign flags_mon = {bus.address_read_error_flag_o, bus.syscall_flag_o, bus.break_flag_o,
                       bus.overflow_flag_o, bus.address_write_error_flag_o, bus.eret_flag_o};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_pulse(input logic [5:0] f, input logic [31:0] pc, input logic ds);
      exp_t e;
      e.is_redir = 1'b0; e.flags = f; e.pc = pc; e.ds = ds;
      exp_q.push_back(e);
   endtask

   task automatic push_redir(input logic [31:0] pc);
      exp_t e;
      e.is_redir = 1'b1; e.flags = '0; e.pc = pc; e.ds = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [5:0] f, input logic [31:0] pc, input logic ds, input logic v);
      bus.mem_adel_i      = f[5];
      bus.mem_syscall_i   = f[4];
      bus.mem_break_i     = f[3];
      bus.mem_overflow_i  = f[2];
      bus.mem_ades_i      = f[1];
      bus.mem_eret_i      = f[0];
      bus.mem_pc_i        = pc;
      bus.mem_delayslot_i = ds;
      bus.mem_valid_i     = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.mem_valid_i = 1'b0; bus.mem_pc_i = '0; bus.mem_delayslot_i = 1'b0;
      bus.mem_adel_i = 1'b0; bus.mem_syscall_i = 1'b0; bus.mem_break_i = 1'b0;
      bus.mem_overflow_i = 1'b0; bus.mem_ades_i = 1'b0; bus.mem_eret_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flush"},     32'(bus.flush_o), 32'd0);
      chk({tag, "_stall"},     32'(bus.stall_o), 32'd0);
      chk({tag, "_rvalid"},    32'(bus.redirect_valid_o), 32'd0);
      chk({tag, "_rpc"},       bus.redirect_pc_o, 32'd0);
      chk({tag, "_flags"},     32'(flags_mon), 32'd0);
      chk({tag, "_cur_pc"},    bus.current_pc_addr_o, 32'd0);
      chk({tag, "_ds"},        32'(bus.delayslot_flag_o), 32'd0);
      chk({tag, "_int"},       32'(bus.int_o), 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT emits a pulse or a redirect.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         flush_run = 0;
         stall_run = 0;
      end else begin
         if (bus.flush_o) flush_run++;
         if (bus.stall_o) stall_run++;
         else if (stall_run != 0) begin
            chk("stall_len", 32'(stall_run), 32'(FLUSH_CYCLES + 1));
            stall_run = 0;
         end
         if (flags_mon != 6'd0) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_pulse: got flags %b, want none", flags_mon);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind",  32'(e.is_redir), 32'd0);
               chk("pulse_flags", 32'(flags_mon), 32'(e.flags));
               chk("pulse_pc",    bus.current_pc_addr_o, e.pc);
               chk("pulse_ds",    32'(bus.delayslot_flag_o), 32'(e.ds));
               chk("pulse_flush_stall", 32'({bus.flush_o, bus.stall_o}), 32'd3);
            end
         end
         if (bus.redirect_valid_o) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_redirect: got pc 0x%08h, want none", bus.redirect_pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("redir_kind",  32'(e.is_redir), 32'd1);
               chk("redirect_pc", bus.redirect_pc_o, e.pc);
               chk("redir_flush_low", 32'(bus.flush_o), 32'd0);
               chk("flush_len",   32'(flush_run), 32'(FLUSH_CYCLES));
            end
            flush_run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] pin  [4];
      logic [5:0] pexp [4];
      pin[0] = F_BRK | F_ADES;          pexp[0] = F_BRK;
      pin[1] = F_OVF | F_ADES | F_ERET; pexp[1] = F_OVF;
      pin[2] = F_ADES;                  pexp[2] = F_ADES;
      pin[3] = F_SYS | F_BRK | F_ERET;  pexp[3] = F_SYS;

      bus.int_i = '0; bus.timer_int_i = 1'b0; bus.cp0_epc_i = '0;
      idle(3);
      chk_all_zero("reset");
      @(negedge clk); rst = 1'b1;
      idle(2);

      // Syscall with default flush length
      push_pulse(F_SYS, 32'h00400010, 1'b0); push_redir(EXC_VEC);
      drive(F_SYS, 32'h00400010, 1'b0, 1'b1);
      idle(5);
      chk("pc_hold", bus.current_pc_addr_o, 32'h00400010);

      // adel beats overflow and eret
      push_pulse(F_ADEL, 32'h00400020, 1'b1); push_redir(EXC_VEC);
      drive(F_ADEL | F_OVF | F_ERET, 32'h00400020, 1'b1, 1'b1);
      idle(5);
      chk("ds_hold", 32'(bus.delayslot_flag_o), 32'd1);

      // eret returns to EPC
      bus.cp0_epc_i = 32'h00400100;
      push_pulse(F_ERET, 32'h00400200, 1'b0); push_redir(32'h00400100);
      drive(F_ERET, 32'h00400200, 1'b0, 1'b1);
      idle(5);

      // Invalid instruction is ignored
      drive(F_BRK, 32'h00400300, 1'b0, 1'b0);
      chk("invalid_no_flush", 32'(bus.flush_o), 32'd0);
      chk("invalid_no_stall", 32'(bus.stall_o), 32'd0);
      idle(3);

      // Event during FLUSH ignored; event in first IDLE cycle accepted
      push_pulse(F_SYS, 32'h00400400, 1'b0); push_redir(EXC_VEC);
      drive(F_SYS, 32'h00400400, 1'b0, 1'b1);
      drive(F_SYS, 32'h00400404, 1'b0, 1'b1);
      chk("pc_during_flush", bus.current_pc_addr_o, 32'h00400400);
      idle(2);
      push_pulse(F_SYS, 32'h00400408, 1'b0); push_redir(EXC_VEC);
      drive(F_SYS, 32'h00400408, 1'b0, 1'b1);
      idle(5);

      for (int i = 0; i < 4; i++) begin
         push_pulse(pexp[i], 32'h00401000 + 32'(i * 4), 1'(i & 1)); push_redir(EXC_VEC);
         drive(pin[i], 32'h00401000 + 32'(i * 4), 1'(i & 1), 1'b1);
         idle(5);
      end

      // Asynchronous reset in the middle of FLUSH
      push_pulse(F_SYS, 32'h00400500, 1'b1);
      drive(F_SYS, 32'h00400500, 1'b1, 1'b1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk_all_zero("midreset");
      idle(2);
      @(negedge clk); rst = 1'b1;
      idle(6);
      chk("queue_after_reset", 32'(exp_q.size()), 32'd0);
      push_pulse(F_BRK, 32'h00400600, 1'b0); push_redir(EXC_VEC);
      drive(F_BRK, 32'h00400600, 1'b0, 1'b1);
      idle(5);

      // Interrupt synchroniser and timer bypass
      @(negedge clk); #2;
      bus.int_i = 6'b000101;
      #1 chk("int_immediate", 32'(bus.int_o), 32'd0);
      @(posedge clk); #1 chk("int_edge1", 32'(bus.int_o), 32'd0);
      @(posedge clk); #1 chk("int_edge2", 32'(bus.int_o), 32'b000101);
      bus.timer_int_i = 1'b1;
      #1 chk("timer_comb", 32'(bus.int_o), 32'b100101);
      bus.timer_int_i = 1'b0;
      #1 chk("timer_release", 32'(bus.int_o), 32'b000101);
      idle(3);
      chk("int_no_stall", 32'(bus.stall_o), 32'd0);
      bus.int_i = '0;

      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
